gpio_bank_ctrl: RTL

- Parametrised GPIO bank that generalises the pad-level GPIO wiring from a fixed 16 pins to NUM_PINS pins.
- Adds a memory-mapped register file, input synchronisation, per-pin debounce, atomic set/clear/toggle and edge-triggered interrupts.
- Sits between the CPU native memory bus and the ihp_io_tri_pad GPIO instances.
- Drives active-low out-enable and pull controls directly to the pads.

---
 rtl/gpio_bank_ctrl_if.sv | 14 +
 rtl/gpio_bank_ctrl.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/gpio_bank_ctrl_if.sv
// Native CPU memory bus used to reach the GPIO bank register file.
interface gpio_bank_ctrl_if;
  logic        mem_valid;
  logic [7:0]  mem_addr;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ready;

  modport master (output mem_valid, mem_addr, mem_wstrb, mem_wdata,
                  input  mem_rdata, mem_ready);
  modport slave  (input  mem_valid, mem_addr, mem_wstrb, mem_wdata,
                  output mem_rdata, mem_ready);
endinterface

// File: rtl/gpio_bank_ctrl.sv
// Parametrised GPIO bank: register file, input synchroniser, per-pin debounce,
// atomic set/clear/toggle and edge-triggered level interrupt.
module gpio_bank_ctrl #(
  parameter int NUM_PINS    = 16,
  parameter int SYNC_STAGES = 2,
  parameter int DBNC_W      = 8
) (
  input  logic                clk_i,
  input  logic                rst_i,
  gpio_bank_ctrl_if.slave     mem,
  input  logic [NUM_PINS-1:0] gpio_in_i,
  output logic [NUM_PINS-1:0] gpio_out_o,
  output logic [NUM_PINS-1:0] gpio_outenb_o,
  output logic [NUM_PINS-1:0] gpio_pullupb_o,
  output logic [NUM_PINS-1:0] gpio_pulldownb_o,
  output logic                irq_o
);
  typedef enum logic [3:0] {
    SEL_OUT, SEL_OUTENB, SEL_PULLUPB, SEL_PULLDOWNB, SEL_IN,
    SEL_SET, SEL_CLR, SEL_TGL, SEL_IRQ_EN, SEL_IRQ_RISE,
    SEL_IRQ_FALL, SEL_IRQ_PEND, SEL_DBNC, SEL_NONE
  } sel_e;

  function automatic sel_e decode(input logic [7:0] addr);
    casez (addr)
      8'b0000_00??: decode = SEL_OUT;
      8'b0000_01??: decode = SEL_OUTENB;
      8'b0000_10??: decode = SEL_PULLUPB;
      8'b0000_11??: decode = SEL_PULLDOWNB;
      8'b0001_00??: decode = SEL_IN;
      8'b0001_01??: decode = SEL_SET;
      8'b0001_10??: decode = SEL_CLR;
      8'b0001_11??: decode = SEL_TGL;
      8'b0010_00??: decode = SEL_IRQ_EN;
      8'b0010_01??: decode = SEL_IRQ_RISE;
      8'b0010_10??: decode = SEL_IRQ_FALL;
      8'b0010_11??: decode = SEL_IRQ_PEND;
      8'b0011_00??: decode = SEL_DBNC;
      default:      decode = SEL_NONE;
    endcase
  endfunction

  logic [NUM_PINS-1:0] out_q, outenb_q, pullupb_q, pulldownb_q;
  logic [NUM_PINS-1:0] irq_en_q, irq_rise_q, irq_fall_q, irq_pend_q;
  logic [DBNC_W-1:0]   dbnc_q, dbnc_wr;
  logic [NUM_PINS-1:0] stable_q, synced, differ, accept, rise, fall;
  logic [NUM_PINS-1:0] sync_q [SYNC_STAGES];
  logic [DBNC_W-1:0]   cnt_q  [NUM_PINS];
  logic [NUM_PINS-1:0] bmask, wdat, pend_set, pend_clr;
  logic [31:0]         rd_val, rdata_q;
  logic                ready_q, req, wr_en;
  sel_e                sel;

  assign sel   = decode(mem.mem_addr);
  assign req   = mem.mem_valid & ~ready_q;
  // Master holds the request through the ready cycle, so commit writes then.
  assign wr_en = ready_q & mem.mem_valid & (|mem.mem_wstrb);

  always_comb begin
    bmask   = '0;
    wdat    = '0;
    dbnc_wr = dbnc_q;
    for (int i = 0; i < NUM_PINS; i++) begin
      bmask[i] = mem.mem_wstrb[i/8];
      wdat[i]  = mem.mem_wdata[i] & mem.mem_wstrb[i/8];
    end
    for (int i = 0; i < DBNC_W; i++)
      if (mem.mem_wstrb[i/8]) dbnc_wr[i] = mem.mem_wdata[i];
  end

  always_comb begin
    rd_val = '0;
    case (sel)
      SEL_OUT:       rd_val[NUM_PINS-1:0] = out_q;
      SEL_OUTENB:    rd_val[NUM_PINS-1:0] = outenb_q;
      SEL_PULLUPB:   rd_val[NUM_PINS-1:0] = pullupb_q;
      SEL_PULLDOWNB: rd_val[NUM_PINS-1:0] = pulldownb_q;
      SEL_IN:        rd_val[NUM_PINS-1:0] = stable_q;
      SEL_IRQ_EN:    rd_val[NUM_PINS-1:0] = irq_en_q;
      SEL_IRQ_RISE:  rd_val[NUM_PINS-1:0] = irq_rise_q;
      SEL_IRQ_FALL:  rd_val[NUM_PINS-1:0] = irq_fall_q;
      SEL_IRQ_PEND:  rd_val[NUM_PINS-1:0] = irq_pend_q;
      SEL_DBNC:      rd_val[DBNC_W-1:0]   = dbnc_q;
      default:       rd_val = '0;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ready_q <= 1'b0;
      rdata_q <= '0;
    end else begin
      ready_q <= req;
      rdata_q <= req ? rd_val : '0;
    end
  end

  // Synchroniser chain and debounce; a pin is accepted after DBNC+1 differing cycles.
  assign synced = sync_q[SYNC_STAGES-1];

  always_comb begin
    differ = synced ^ stable_q;
    accept = '0;
    for (int i = 0; i < NUM_PINS; i++)
      accept[i] = differ[i] && (cnt_q[i] >= dbnc_q);
  end

  assign rise     = accept & synced;
  assign fall     = accept & ~synced;
  assign pend_set = (rise & irq_rise_q) | (fall & irq_fall_q);
  assign pend_clr = (wr_en && sel == SEL_IRQ_PEND) ? wdat : '0;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
      for (int i = 0; i < NUM_PINS; i++) cnt_q[i] <= '0;
      stable_q <= '0;
    end else begin
      sync_q[0] <= gpio_in_i;
      for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
      for (int i = 0; i < NUM_PINS; i++)
        cnt_q[i] <= (!differ[i] || accept[i]) ? '0 : cnt_q[i] + 1'b1;
      stable_q <= stable_q ^ accept;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      out_q       <= '0;
      outenb_q    <= '1;
      pullupb_q   <= '1;
      pulldownb_q <= '1;
      irq_en_q    <= '0;
      irq_rise_q  <= '0;
      irq_fall_q  <= '0;
      irq_pend_q  <= '0;
      dbnc_q      <= '0;
    end else begin
      if (wr_en) begin
        case (sel)
          SEL_OUT:       out_q       <= (out_q & ~bmask) | wdat;
          SEL_OUTENB:    outenb_q    <= (outenb_q & ~bmask) | wdat;
          SEL_PULLUPB:   pullupb_q   <= (pullupb_q & ~bmask) | wdat;
          SEL_PULLDOWNB: pulldownb_q <= (pulldownb_q & ~bmask) | wdat;
          SEL_SET:       out_q       <= out_q | wdat;
          SEL_CLR:       out_q       <= out_q & ~wdat;
          SEL_TGL:       out_q       <= out_q ^ wdat;
          SEL_IRQ_EN:    irq_en_q    <= (irq_en_q & ~bmask) | wdat;
          SEL_IRQ_RISE:  irq_rise_q  <= (irq_rise_q & ~bmask) | wdat;
          SEL_IRQ_FALL:  irq_fall_q  <= (irq_fall_q & ~bmask) | wdat;
          SEL_DBNC:      dbnc_q      <= dbnc_wr;
          default:       ;
        endcase
      end
      // A new edge outranks a simultaneous write-one-to-clear.
      irq_pend_q <= (irq_pend_q & ~pend_clr) | pend_set;
    end
  end

  assign mem.mem_ready    = ready_q;
  assign mem.mem_rdata    = rdata_q;
  assign gpio_out_o       = out_q;
  assign gpio_outenb_o    = outenb_q;
  assign gpio_pullupb_o   = pullupb_q;
  assign gpio_pulldownb_o = pulldownb_q;
  assign irq_o            = |(irq_pend_q & irq_en_q);
endmodule
